dut_initiator: RTL and testbench

- Initiator/driver end of the dut write/read en/rdy interface.
- Accepts single transactions (write or read) on a valid/ready command port.
- Drives write_en/read_en only when the dut's matching rdy is high, and captures read_data in the firing cycle.
- Returns one response per command. Sits between a test sequencer or bus master and the dut; one transaction in flight at a time.

---
 rtl/dut_initiator.sv | 137 +++++++++++++
 tb/tb_dut_initiator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_initiator.sv
// Initiator for the dut write/read en/rdy interface: one command in, one transaction out, one response back.
// Optional DUT_INITIATOR_STATS_EN adds saturating wr/rd/timeout event counters.
module dut_initiator #(
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_read,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_read,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error
`ifdef DUT_INITIATOR_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic [15:0]       to_count
`endif
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic              lat_is_read;
  logic [ADDR_W-1:0] lat_address;
  logic [DATA_W-1:0] lat_data;
  logic [CNT_W-1:0]  wait_cnt;
  logic              in_issue;
  logic              fire;
  logic              timeout_hit;

  // Enables are combinational so a fire lands in the same cycle rdy is seen.
  assign in_issue    = (state == ISSUE) && !RST;
  assign write_en    = in_issue && !lat_is_read && write_rdy;
  assign read_en     = in_issue && lat_is_read && read_rdy;
  assign fire        = write_en || read_en;
  assign timeout_hit = in_issue && !fire && (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  assign write_address = lat_address;
  assign write_data    = lat_data;
  assign read_address  = lat_address;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      lat_is_read <= 1'b0;
      lat_address <= '0;
      lat_data    <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_is_read <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_is_read <= cmd_is_read;
            lat_address <= cmd_address;
            lat_data    <= cmd_data;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            rsp_valid   <= 1'b1;
            rsp_is_read <= lat_is_read;
            rsp_data    <= lat_is_read ? read_data : '0;
            rsp_error   <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_is_read <= lat_is_read;
            rsp_data    <= '0;
            rsp_error   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUT_INITIATOR_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_count <= '0;
      rd_count <= '0;
      to_count <= '0;
    end else begin
      if (write_en)    wr_count <= sat_inc16(wr_count);
      if (read_en)     rd_count <= sat_inc16(rd_count);
      if (timeout_hit) to_count <= sat_inc16(to_count);
    end
  end
`endif

endmodule

// File: tb/tb_dut_initiator.sv
// Scoreboard bench for dut_initiator: default-timeout instance plus a TIMEOUT_CYCLES=4 instance.
module tb_dut_initiator;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 1;

  typedef struct packed {
    logic              is_read;
    logic [DATA_W-1:0] data;
    logic              error;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_valid4, cmd_is_read, write_rdy, read_rdy, rsp_ready, rsp_ready4;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_data, read_data;

  logic cmd_ready, write_en, read_en, rsp_valid, rsp_is_read, rsp_error;
  logic [ADDR_W-1:0] write_address, read_address;
  logic [DATA_W-1:0] write_data, rsp_data;

  logic cmd_ready4, write_en4, read_en4, rsp_valid4, rsp_is_read4, rsp_error4;
  logic [ADDR_W-1:0] write_address4, read_address4;
  logic [DATA_W-1:0] write_data4, rsp_data4;

`ifdef DUT_INITIATOR_STATS_EN
  logic [15:0] wr_count, rd_count, to_count, wr_count4, rd_count4, to_count4;
`endif

  int errors = 0;
  int checks = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  int exp_to4 = 0;
  rsp_t sb[$];
  rsp_t e;

  always #5 clk = ~clk;

  dut_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(cmd_is_read),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_read(rsp_is_read),
    .rsp_data(rsp_data), .rsp_error(rsp_error)
`ifdef DUT_INITIATOR_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count), .to_count(to_count)
`endif
  );

  dut_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut4 (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_is_read(cmd_is_read),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .write_address(write_address4), .write_data(write_data4), .write_en(write_en4),
    .write_rdy(write_rdy), .read_address(read_address4), .read_en(read_en4),
    .read_data(read_data), .read_rdy(read_rdy),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_is_read(rsp_is_read4),
    .rsp_data(rsp_data4), .rsp_error(rsp_error4)
`ifdef DUT_INITIATOR_STATS_EN
    , .wr_count(wr_count4), .rd_count(rd_count4), .to_count(to_count4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid   = 1'b1;
    cmd_is_read = rd;
    cmd_address = a;
    cmd_data    = d;
    tick();
    cmd_valid   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, cmd_ready4} !== 2'b11) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 11", {cmd_ready, cmd_ready4});
    end
    checks++;
    if ({write_en, read_en, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_en_valid: got %b want 000", {write_en, read_en, rsp_valid});
    end
    checks++;
    if ({rsp_is_read, rsp_data, rsp_error} !== 3'b000) begin
      errors++; $display("FAIL reset_rsp: got %b want 000", {rsp_is_read, rsp_data, rsp_error});
    end
    checks++;
    if ({write_address, write_data, read_address} !== 7'd0) begin
      errors++; $display("FAIL reset_addr_data: got %b want 0", {write_address, write_data, read_address});
    end
  endtask

  task automatic test_write();
    write_rdy = 1'b1; rsp_ready = 1'b1;
    sb.push_back('{is_read: 1'b0, data: 1'b0, error: 1'b0});
    send_cmd(1'b0, 3'd3, 1'b1);
    checks++;
    if ({write_en, read_en, write_address, write_data} !== {2'b10, 3'd3, 1'b1}) begin
      errors++; $display("FAIL write_fire: got %b want 100111", {write_en, read_en, write_address, write_data});
    end
    tick();
    exp_wr++;
    checks++;
    if (write_en !== 1'b0) begin
      errors++; $display("FAIL write_single_pulse: write_en=%b want 0", write_en);
    end
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error} !== {1'b1, e}) begin
      errors++; $display("FAIL write_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error}, {1'b1, e});
    end
    tick();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL write_idle: got %b want 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read();
    read_rdy = 1'b1; read_data = 1'b1; rsp_ready = 1'b1;
    sb.push_back('{is_read: 1'b1, data: 1'b1, error: 1'b0});
    send_cmd(1'b1, 3'd5, 1'b0);
    checks++;
    if ({read_en, write_en, read_address} !== {2'b10, 3'd5}) begin
      errors++; $display("FAIL read_fire: got %b want 10101", {read_en, write_en, read_address});
    end
    tick();
    exp_rd++;
    read_data = 1'b0;
    #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error, read_en} !== {1'b1, e, 1'b0}) begin
      errors++; $display("FAIL read_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error, read_en}, {1'b1, e, 1'b0});
    end
    tick();
  endtask

  task automatic test_delayed_rdy();
    write_rdy = 1'b0; read_rdy = 1'b1; rsp_ready = 1'b1;
    sb.push_back('{is_read: 1'b0, data: 1'b0, error: 1'b0});
    send_cmd(1'b0, 3'd6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({write_en, read_en, rsp_valid} !== 3'b000) begin
        errors++; $display("FAIL delayed_wait[%0d]: got %b want 000", i, {write_en, read_en, rsp_valid});
      end
      tick();
    end
    write_rdy = 1'b1;
    #1;
    checks++;
    if ({write_en, write_address} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL delayed_fire: got %b want 1110", {write_en, write_address});
    end
    tick();
    exp_wr++;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error} !== {1'b1, e}) begin
      errors++; $display("FAIL delayed_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error}, {1'b1, e});
    end
    tick();
  endtask

  task automatic test_timeout();
    read_rdy = 1'b0; read_data = 1'b1; rsp_ready4 = 1'b0;
    sb.push_back('{is_read: 1'b1, data: 1'b0, error: 1'b1});
    cmd_valid4 = 1'b1; cmd_is_read = 1'b1; cmd_address = 3'd4; cmd_data = 1'b0;
    tick();
    cmd_valid4 = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({read_en4, write_en4, rsp_valid4} !== 3'b000) begin
        errors++; $display("FAIL timeout_wait[%0d]: got %b want 000", i, {read_en4, write_en4, rsp_valid4});
      end
      tick();
    end
    exp_to4++;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid4, rsp_is_read4, rsp_data4, rsp_error4} !== {1'b1, e}) begin
      errors++; $display("FAIL timeout_rsp: got %b want %b", {rsp_valid4, rsp_is_read4, rsp_data4, rsp_error4}, {1'b1, e});
    end
    rsp_ready4 = 1'b1;
    tick();
    checks++;
    if ({cmd_ready4, rsp_valid4} !== 2'b10) begin
      errors++; $display("FAIL timeout_idle: got %b want 10", {cmd_ready4, rsp_valid4});
    end
  endtask

  task automatic test_backpressure();
    read_rdy = 1'b1; read_data = 1'b1; write_rdy = 1'b1; rsp_ready = 1'b0;
    sb.push_back('{is_read: 1'b1, data: 1'b1, error: 1'b0});
    send_cmd(1'b1, 3'd4, 1'b0);
    tick();
    exp_rd++;
    read_data = 1'b0;
    cmd_valid = 1'b1; cmd_is_read = 1'b0; cmd_address = 3'd7; cmd_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_data, cmd_ready, write_en, read_en} !== 5'b11000) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b want 11000", i, {rsp_valid, rsp_data, cmd_ready, write_en, read_en});
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error} !== {1'b1, e}) begin
      errors++; $display("FAIL bp_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error}, {1'b1, e});
    end
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, write_en} !== 3'b100) begin
      errors++; $display("FAIL bp_idle: got %b want 100", {cmd_ready, rsp_valid, write_en});
    end
  endtask

  task automatic test_back_to_back();
    read_rdy = 1'b1; write_rdy = 1'b1; read_data = 1'b0; rsp_ready = 1'b1;
    sb.push_back('{is_read: 1'b1, data: 1'b0, error: 1'b0});
    sb.push_back('{is_read: 1'b0, data: 1'b0, error: 1'b0});
    send_cmd(1'b1, 3'd2, 1'b1);
    checks++;
    if ({write_en, read_en, read_address} !== {2'b01, 3'd2}) begin
      errors++; $display("FAIL b2b_read_fire: got %b want 01010", {write_en, read_en, read_address});
    end
    tick();
    exp_rd++;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error} !== {1'b1, e}) begin
      errors++; $display("FAIL b2b_read_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error}, {1'b1, e});
    end
    tick();
    send_cmd(1'b0, 3'd1, 1'b0);
    checks++;
    if ({write_en, read_en, write_address, write_data} !== {2'b10, 3'd1, 1'b0}) begin
      errors++; $display("FAIL b2b_write_fire: got %b want 100010", {write_en, read_en, write_address, write_data});
    end
    tick();
    exp_wr++;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_is_read, rsp_data, rsp_error} !== {1'b1, e}) begin
      errors++; $display("FAIL b2b_write_rsp: got %b want %b", {rsp_valid, rsp_is_read, rsp_data, rsp_error}, {1'b1, e});
    end
    tick();
  endtask

  task automatic test_reset_in_issue();
    write_rdy = 1'b0; read_rdy = 1'b0; rsp_ready = 1'b1;
    send_cmd(1'b0, 3'd2, 1'b1);
    tick();
    rst = 1'b1;
    write_rdy = 1'b1;
    #1;
    checks++;
    if (write_en !== 1'b0) begin
      errors++; $display("FAIL rst_issue_gate: write_en=%b want 0", write_en);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, write_en, write_address} !== {3'b100, 3'd0}) begin
      errors++; $display("FAIL rst_issue_after: got %b want 100000", {cmd_ready, rsp_valid, write_en, write_address});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({write_en, read_en, rsp_valid} !== 3'b000) begin
        errors++; $display("FAIL rst_issue_quiet[%0d]: got %b want 000", i, {write_en, read_en, rsp_valid});
      end
    end
`ifdef DUT_INITIATOR_STATS_EN
    exp_wr = 0; exp_rd = 0; exp_to4 = 0;
`endif
  endtask

  task automatic test_stats();
`ifdef DUT_INITIATOR_STATS_EN
    write_rdy = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b0, 3'd0, 1'b1);
    tick();
    exp_wr++;
    tick();
    checks++;
    if ({wr_count, rd_count, to_count4} !== {16'(exp_wr), 16'(exp_rd), 16'(exp_to4)}) begin
      errors++; $display("FAIL stats_counts: wr=%0d rd=%0d to=%0d want %0d %0d %0d",
                         wr_count, rd_count, to_count4, exp_wr, exp_rd, exp_to4);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0; cmd_is_read = 1'b0;
    cmd_address = '0; cmd_data = '0; write_rdy = 1'b0; read_rdy = 1'b0;
    read_data = '0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_delayed_rdy();
`ifdef DUT_INITIATOR_STATS_EN
    checks++;
    if ({wr_count, rd_count} !== {16'(exp_wr), 16'(exp_rd)}) begin
      errors++; $display("FAIL stats_mid: wr=%0d rd=%0d want %0d %0d", wr_count, rd_count, exp_wr, exp_rd);
    end
`endif
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_in_issue();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
